// File: rtl/spm_serdes_ctrl.sv
// Operand serializer / product deserializer for the spm serial-parallel multiplier.
// Holds x on the array, streams y LSB-first and gathers the serial product into out_p.
module spm_serdes_ctrl #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned YWIDTH = 32,
  parameter int unsigned LAT    = 1,
  parameter bit          SIGNED = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_x,
  input  logic [YWIDTH-1:0]         in_y,
  output logic [WIDTH-1:0]          spm_x,
  output logic                      spm_y,
  output logic                      spm_clr,
  input  logic                      spm_p,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH+YWIDTH-1:0]   out_p
);

  localparam int unsigned PW      = WIDTH + YWIDTH;
  localparam int unsigned RUN_LEN = PW + LAT;
  localparam int unsigned CW      = $clog2(RUN_LEN + 1);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [YWIDTH-1:0]   y_sh;
  logic [PW-1:0]       p_sh;
  logic                y_fill;
  logic                last;
  logic [PW-1:0]       p_next;

  // Tail of the y stream: sign extension for two's complement, zeros otherwise.
  assign y_fill = SIGNED ? y_sh[YWIDTH-1] : 1'b0;
  assign p_next = {spm_p, p_sh[PW-1:1]};
  assign last   = (cnt == CW'(RUN_LEN - 1));

  // spm_y is registered one cycle ahead so the bit for cnt=c is on the wire during cnt=c.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      y_sh      <= '0;
      p_sh      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      spm_x     <= '0;
      spm_y     <= 1'b0;
      spm_clr   <= 1'b0;
      out_p     <= '0;
    end else begin
      spm_clr <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            spm_x    <= in_x;
            y_sh     <= in_y;
            p_sh     <= '0;
            spm_clr  <= 1'b1;
            in_ready <= 1'b0;
            state    <= CLEAR;
          end
        end
        CLEAR: begin
          cnt   <= '0;
          spm_y <= y_sh[0];
          y_sh  <= {y_fill, y_sh[YWIDTH-1:1]};
          state <= RUN;
        end
        RUN: begin
          cnt   <= cnt + CW'(1);
          spm_y <= (cnt < CW'(PW - 1)) ? y_sh[0] : 1'b0;
          y_sh  <= {y_fill, y_sh[YWIDTH-1:1]};
          if (cnt >= CW'(LAT)) begin
            p_sh <= p_next;
          end
          if (last) begin
            spm_y     <= 1'b0;
            out_p     <= p_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
